// File: rtl/cpu_mem_map_pkg.sv
// Word-address map of the core's data bus and the STATUS register bit layout.
package cpu_mem_map_pkg;

    // Region boundaries and register addresses (word addresses)
    localparam int RAM_LIMIT      = 'hF0;
    localparam int ADDR_TIMER_CNT = 'hF0;
    localparam int ADDR_TIMER_CMP = 'hF1;
    localparam int ADDR_STATUS    = 'hF2;
    localparam int ADDR_TX_DATA   = 'hF3;
    localparam int ADDR_IRQ_EN    = 'hF4;

    // STATUS bit positions
    localparam int STAT_FIFO_FULL   = 0;
    localparam int STAT_FIFO_EMPTY  = 1;
    localparam int STAT_TIMER_MATCH = 2;
    localparam int STAT_TX_OVERFLOW = 3;

    // Which source feeds read_data in the cycle after the address is sampled
    typedef enum logic [1:0] {
        RSEL_ZERO = 2'd0,
        RSEL_RAM  = 2'd1,
        RSEL_REG  = 2'd2
    } rsel_e;

endpackage

// File: rtl/data_bus_mmio_sync_fifo.sv
// Small synchronous FIFO; the head entry is read straight out of the storage
// flops so dout is stable whenever no pop happens. A push while full is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_fire;
    logic             w_push_fire;

    assign full        = (r_count == CW'(DEPTH));
    assign empty       = (r_count == '0);
    assign dout        = r_mem[r_rd_ptr];
    assign w_pop_fire  = pop && !empty;
    assign w_push_fire = push && (!full || w_pop_fire);

    // Storage, pointers and occupancy; reset empties the queue and clears the array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_fire && !w_pop_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_fire && w_pop_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_bus_mmio.sv
// Data-side memory system for the core: RAM, free-running timer with compare,
// and a console TX FIFO, all behind one registered read port.
// Optional build macro TIMER_IRQ_EN adds the IRQ_EN register and the irq output.
module data_bus_mmio
    import cpu_mem_map_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_WORDS  = 240,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
`ifdef TIMER_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [DATA_WIDTH-1:0] r_ram [0:RAM_WORDS-1];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [DATA_WIDTH-1:0] r_reg_q;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic                  r_tmatch;
    logic                  r_ovf;
    rsel_e                 r_rsel;

    logic [DATA_WIDTH-1:0] w_reg_rdata;
    logic [DATA_WIDTH-1:0] w_status;
    rsel_e                 w_rsel;
    logic [RAM_AW-1:0]     w_ram_idx;
    logic                  w_in_ram;
    logic                  w_wr_cnt;
    logic                  w_wr_cmp;
    logic                  w_wr_status;
    logic                  w_wr_tx;
    logic                  w_match;
    logic                  w_ovf_event;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    // Address decode
    assign w_in_ram    = (32'(data_address) < RAM_WORDS);
    assign w_ram_idx   = data_address[RAM_AW-1:0];
    assign w_wr_cnt    = write_enable && (data_address == ADDR_WIDTH'(ADDR_TIMER_CNT));
    assign w_wr_cmp    = write_enable && (data_address == ADDR_WIDTH'(ADDR_TIMER_CMP));
    assign w_wr_status = write_enable && (data_address == ADDR_WIDTH'(ADDR_STATUS));
    assign w_wr_tx     = write_enable && (data_address == ADDR_WIDTH'(ADDR_TX_DATA));

    // Compare uses the count before this cycle's increment/load
    assign w_match = (r_cnt == r_cmp);

    // A push is dropped only when full and nothing pops (full implies a valid head)
    assign w_ovf_event = w_wr_tx && w_fifo_full && !tx_ready;

    // RAM store and registered read; the read sees the pre-store contents.
    // Stores are suppressed while reset is held so a pending store is discarded.
    always_ff @(posedge clk) begin
        if (write_enable && w_in_ram && reset_n) begin
            r_ram[w_ram_idx] <= write_data;
        end
        r_ram_q <= r_ram[w_ram_idx];
    end

    // Timer: load on write, otherwise free-run with natural wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_cmp <= '1;
        end else begin
            r_cnt <= w_wr_cnt ? write_data : r_cnt + 1'b1;
            if (w_wr_cmp) begin
                r_cmp <= write_data;
            end
        end
    end

    // Sticky STATUS bits: W1C clears, but a same-cycle set event wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmatch <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_tmatch <= w_match ||
                        (r_tmatch && !(w_wr_status && write_data[STAT_TIMER_MATCH]));
            r_ovf    <= w_ovf_event ||
                        (r_ovf && !(w_wr_status && write_data[STAT_TX_OVERFLOW]));
        end
    end

`ifdef TIMER_IRQ_EN
    logic r_irq_en;
    logic w_wr_irq_en;

    assign w_wr_irq_en = write_enable && (data_address == ADDR_WIDTH'(ADDR_IRQ_EN));

    // Interrupt enable register, bit0 only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_irq_en) begin
            r_irq_en <= write_data[0];
        end
    end

    assign irq = r_tmatch && r_irq_en;
`endif

    // STATUS assembly from live FIFO state and sticky flags
    always_comb begin
        w_status                   = '0;
        w_status[STAT_FIFO_FULL]   = w_fifo_full;
        w_status[STAT_FIFO_EMPTY]  = w_fifo_empty;
        w_status[STAT_TIMER_MATCH] = r_tmatch;
        w_status[STAT_TX_OVERFLOW] = r_ovf;
    end

    // Read source selection and register-side read data for this address
    always_comb begin
        w_rsel      = RSEL_ZERO;
        w_reg_rdata = '0;
        if (w_in_ram) begin
            w_rsel = RSEL_RAM;
        end else begin
            case (data_address)
                ADDR_WIDTH'(ADDR_TIMER_CNT): begin
                    w_rsel      = RSEL_REG;
                    w_reg_rdata = r_cnt;
                end
                ADDR_WIDTH'(ADDR_TIMER_CMP): begin
                    w_rsel      = RSEL_REG;
                    w_reg_rdata = r_cmp;
                end
                ADDR_WIDTH'(ADDR_STATUS): begin
                    w_rsel      = RSEL_REG;
                    w_reg_rdata = w_status;
                end
`ifdef TIMER_IRQ_EN
                ADDR_WIDTH'(ADDR_IRQ_EN): begin
                    w_rsel         = RSEL_REG;
                    w_reg_rdata[0] = r_irq_en;
                end
`endif
                default: begin
                    w_rsel      = RSEL_ZERO;
                    w_reg_rdata = '0;
                end
            endcase
        end
    end

    // Registered read path; RSEL_ZERO keeps r_reg_q at zero so read_data resets to 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsel  <= RSEL_ZERO;
            r_reg_q <= '0;
        end else begin
            r_rsel  <= w_rsel;
            r_reg_q <= w_reg_rdata;
        end
    end

    assign read_data = (r_rsel == RSEL_RAM) ? r_ram_q : r_reg_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_wr_tx),
        .pop     (tx_ready),
        .din     (write_data[7:0]),
        .dout    (tx_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign tx_valid = !w_fifo_empty;

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio: RAM, timer/compare, STATUS W1C, TX FIFO, reset.
module tb_data_bus_mmio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef TIMER_IRQ_EN
    logic        irq;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] drain_exp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};

    data_bus_mmio dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_address (addr),
        .write_data   (wdata),
        .write_enable (we),
        .read_data    (rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
`ifdef TIMER_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [7:0] a, input logic [31:0] d, input logic w);
        addr  = a;
        wdata = d;
        we    = w;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_bus(a, d, 1'b1);
        tick;
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        set_bus(a, 32'h0, 1'b0);
        tick;
        chk(tag, rdata, exp);
    endtask

    initial begin
        reset_n  = 1'b0;
        tx_ready = 1'b0;
        set_bus(8'h00, 32'h0, 1'b0);
        tick;
        tick;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);
        #2 reset_n = 1'b1;

        rd(8'hF2, 32'h2, "rst_status");
        rd(8'hF1, 32'hFFFF_FFFF, "rst_cmp");

        // RAM write/read and read-before-write
        wr(8'h10, 32'hDEAD_BEEF);
        rd(8'h10, 32'hDEAD_BEEF, "ram_rd");
        set_bus(8'h10, 32'h1, 1'b1);
        tick;
        chk("ram_rbw", rdata, 32'hDEAD_BEEF);
        set_bus(8'h10, 32'h0, 1'b0);
        tick;
        chk("ram_new", rdata, 32'h1);
        wr(8'hEF, 32'h1234_5678);
        rd(8'hEF, 32'h1234_5678, "ram_top");
        wr(8'hF5, 32'hAAAA_5555);
        rd(8'hF5, 32'h0, "unmapped_wr");

        // Timer compare: count loaded to 0, match set on the edge where pre-value is 5
        wr(8'hF0, 32'd100);
        wr(8'hF1, 32'd5);
        wr(8'hF0, 32'd0);
        set_bus(8'hF2, 32'h0, 1'b0);
        repeat (6) tick;
        chk("match_pre", rdata, 32'h2);
        tick;
        chk("match_set", rdata, 32'h6);
`ifdef TIMER_IRQ_EN
        wr(8'hF4, 32'h1);
        chk("irq_on", 32'(irq), 32'h1);
`endif
        wr(8'hF2, 32'h4);
        rd(8'hF2, 32'h2, "match_w1c");
`ifdef TIMER_IRQ_EN
        chk("irq_off", 32'(irq), 32'h0);
`endif

        // Same-cycle match and W1C: set wins
        wr(8'hF1, 32'h40);
        wr(8'hF0, 32'h3E);
        set_bus(8'hF2, 32'h0, 1'b0);
        tick;
        tick;
        set_bus(8'hF2, 32'h4, 1'b1);
        tick;
        set_bus(8'hF2, 32'h0, 1'b0);
        tick;
        chk("match_setwins", rdata, 32'h6);
        wr(8'hF1, 32'hFFFF_FFF0);
        wr(8'hF2, 32'h4);
        rd(8'hF2, 32'h2, "match_clr2");

        // Counter wrap
        wr(8'hF0, 32'hFFFF_FFFE);
        set_bus(8'hF0, 32'h0, 1'b0);
        tick;
        chk("wrap_0", rdata, 32'hFFFF_FFFE);
        tick;
        chk("wrap_1", rdata, 32'hFFFF_FFFF);
        tick;
        chk("wrap_2", rdata, 32'h0);
        rd(8'hF3, 32'h0, "rd_txdata");
        rd(8'hFF, 32'h0, "rd_ff");
`ifndef TIMER_IRQ_EN
        rd(8'hF4, 32'h0, "rd_f4");
`endif

        // Fill FIFO with consumer stalled
        tx_ready = 1'b0;
        chk("txv_empty", 32'(tx_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            wr(8'hF3, 32'h41 + 32'(i));
            if (i == 0) begin
                chk("txv_rise", 32'(tx_valid), 32'h1);
                chk("txd_first", 32'(tx_data), 32'h41);
            end
        end
        rd(8'hF2, 32'h1, "fifo_full");
        wr(8'hF3, 32'h49);
        rd(8'hF2, 32'h9, "fifo_ovf");
        chk("tx_hold", 32'(tx_data), 32'h41);
        rd(8'hF3, 32'h0, "rd_txdata_full");
        wr(8'hF2, 32'h8);
        rd(8'hF2, 32'h1, "ovf_clr");

        // Push and pop together while full
        tx_ready = 1'b1;
        set_bus(8'hF3, 32'h5A, 1'b1);
        tick;
        tx_ready = 1'b0;
        set_bus(8'hF2, 32'h0, 1'b0);
        tick;
        chk("full_pushpop", rdata, 32'h1);

        // Drain
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_v%0d", i), 32'(tx_valid), 32'h1);
            chk($sformatf("drain_d%0d", i), 32'(tx_data), 32'(drain_exp[i]));
            tick;
        end
        chk("drain_done", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Asynchronous reset with entries queued
        wr(8'hF3, 32'h61);
        wr(8'hF3, 32'h62);
        wr(8'hF3, 32'h63);
        chk("q3_valid", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_txv", 32'(tx_valid), 32'h0);
        chk("rst_async_txd", 32'(tx_data), 32'h0);
        tick;
        tx_ready = 1'b0;
        chk("rst_hold_rdata", rdata, 32'h0);
        reset_n = 1'b1;
        rd(8'hF0, 32'h0, "rst_timer");
        rd(8'hF2, 32'h2, "rst_status2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
